// File: rtl/hist_accumulate_pkg.sv
// -----------------------------------------------------------------------------
// hist_accumulate_pkg
// Shared definitions for the histogram front stage:
//   - FSM state encoding (IDLE, READ, COUNT, DUMP, DONE)
//   - pixel/word/bin geometry and the M1/M2 bus and address widths
//   - pixelAt(): extracts byte k of a packed image word (k=0 is bits [7:0])
// -----------------------------------------------------------------------------
package hist_accumulate_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 16;
  localparam int NUM_BINS     = 256;
  localparam int BUS_W        = 128;
  localparam int ADDR_W       = 16;
  localparam int BIN_IDX_W    = 8;   // log2(NUM_BINS)
  localparam int PIX_IDX_W    = 4;   // log2(PIX_PER_WORD)

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    COUNT = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } histState_t;

  // Byte k of a word lives at bits [8k+7:8k]; {k,3'b000} is 8k without
  // overflowing the 4-bit index.
  function automatic logic [PIX_W-1:0] pixelAt(input logic [BUS_W-1:0]     word,
                                                input logic [PIX_IDX_W-1:0] k);
    return word[{k, 3'b000} +: PIX_W];
  endfunction

endpackage

// File: rtl/hist_accumulate_bin_bank.sv
// -----------------------------------------------------------------------------
// hist_bin_bank
// 256 saturating bin counters of COUNT_W bits.
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset, clears every bin
//   clear      in   synchronous clear of every bin (start of a pass)
//   incEnable  in   increment the bin selected by incIndex this edge
//   incIndex   in   bin to increment (the current pixel value)
//   readIndex  in   bin to present on readCount
//   readCount  out  count of bin readIndex (combinational mux)
// A bin that has reached 2^COUNT_W-1 holds there instead of wrapping.
// -----------------------------------------------------------------------------
module hist_bin_bank
  import hist_accumulate_pkg::*;
#(
  parameter int COUNT_W = 20
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 incEnable,
  input  logic [BIN_IDX_W-1:0] incIndex,
  input  logic [BIN_IDX_W-1:0] readIndex,
  output logic [COUNT_W-1:0]   readCount
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [COUNT_W-1:0] binView [NUM_BINS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : gBin
      logic [COUNT_W-1:0] countReg;
      logic               hit;

      assign hit = incEnable && (incIndex == BIN_IDX_W'(gi));

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          countReg <= '0;
        end else if (clear) begin
          countReg <= '0;
        end else if (hit && (countReg != COUNT_MAX)) begin
          countReg <= countReg + 1'b1;
        end
      end

      assign binView[gi] = countReg;
    end
  endgenerate

  assign readCount = binView[readIndex];

endmodule

// File: rtl/hist_accumulate.sv
// -----------------------------------------------------------------------------
// hist_accumulate
// Histogram front stage: on start, streams NUM_WORDS packed 128-bit image
// words (16 pixels each) from M1, builds a 256-bin histogram, then writes
// bin b to M2 at HIST_BASE+b and pulses done.
// Ports:
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset (aborts a pass)
//   start            in   begin one pass; only looked at in IDLE
//   busy             out  high whenever the FSM is not in IDLE
//   done             out  one-cycle pulse after the last bin is written
//   M1_ReadAddress   out  image SRAM read address (IMG_BASE+word, mod 2^16)
//   M1_ReadBus       in   image SRAM read data (combinational SRAM)
//   M2_WriteEnable   out  histogram SRAM write enable (DUMP only)
//   M2_WriteAddress  out  histogram SRAM write address (HIST_BASE+bin)
//   M2_WriteBus      out  bin count in [COUNT_W-1:0], rest zero
// Optional feature, macro HIST_CDF_EN:
//   when defined, M2_WriteBus[2*COUNT_W-1:COUNT_W] carries the saturating
//   cumulative sum of bins 0..b; when undefined that field is zero.
// -----------------------------------------------------------------------------
module hist_accumulate
  import hist_accumulate_pkg::*;
#(
  parameter int                NUM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] IMG_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] HIST_BASE = 16'h0000,
  parameter int                COUNT_W   = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] M1_ReadAddress,
  input  logic [BUS_W-1:0]  M1_ReadBus,
  output logic              M2_WriteEnable,
  output logic [ADDR_W-1:0] M2_WriteAddress,
  output logic [BUS_W-1:0]  M2_WriteBus
);

  localparam logic [ADDR_W-1:0]    LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [PIX_IDX_W-1:0] PIX_PRE   = PIX_IDX_W'(PIX_PER_WORD - 2);
  localparam logic [PIX_IDX_W-1:0] PIX_LAST  = PIX_IDX_W'(PIX_PER_WORD - 1);
  localparam logic [BIN_IDX_W-1:0] BIN_LAST  = BIN_IDX_W'(NUM_BINS - 1);

  histState_t           stateReg;
  logic [ADDR_W-1:0]    wordIdxReg;
  logic [PIX_IDX_W-1:0] pixIdxReg;
  logic [BIN_IDX_W-1:0] binIdxReg;
  logic [BUS_W-1:0]     wordReg;
  logic [ADDR_W-1:0]    m1AddrReg;
  logic [ADDR_W-1:0]    m2AddrReg;
  logic                 writeEnableReg;
  logic                 doneReg;

  logic                 startPass;
  logic [COUNT_W-1:0]   binCount;

  assign startPass = (stateReg == IDLE) && start;

  hist_bin_bank #(
    .COUNT_W (COUNT_W)
  ) uBinBank (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (startPass),
    .incEnable (stateReg == COUNT),
    .incIndex  (pixelAt(wordReg, pixIdxReg)),
    .readIndex (binIdxReg),
    .readCount (binCount)
  );

`ifdef HIST_CDF_EN
  // cdfReg holds the sum of bins 0..b-1; cdfNext adds the bin on the bus
  // so the written value covers 0..b inclusive.
  logic [COUNT_W-1:0] cdfReg;
  logic [COUNT_W:0]   cdfWide;
  logic [COUNT_W-1:0] cdfNext;

  assign cdfWide = {1'b0, cdfReg} + {1'b0, binCount};
  assign cdfNext = cdfWide[COUNT_W] ? '1 : cdfWide[COUNT_W-1:0];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateReg       <= IDLE;
      wordIdxReg     <= '0;
      pixIdxReg      <= '0;
      binIdxReg      <= '0;
      wordReg        <= '0;
      m1AddrReg      <= IMG_BASE;
      m2AddrReg      <= '0;
      writeEnableReg <= 1'b0;
      doneReg        <= 1'b0;
`ifdef HIST_CDF_EN
      cdfReg         <= '0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            stateReg   <= READ;
            wordIdxReg <= '0;
            m1AddrReg  <= IMG_BASE;
          end
        end

        READ: begin
          wordReg   <= M1_ReadBus;
          pixIdxReg <= '0;
          stateReg  <= COUNT;
        end

        COUNT: begin
          pixIdxReg <= pixIdxReg + 1'b1;
          // Point at the next word one cycle early so the k=15 edge can
          // latch it and counting continues without a bubble.
          if (pixIdxReg == PIX_PRE) begin
            m1AddrReg <= IMG_BASE + wordIdxReg + 16'd1;
          end
          if (pixIdxReg == PIX_LAST) begin
            wordReg <= M1_ReadBus;
            if (wordIdxReg == LAST_WORD) begin
              stateReg       <= DUMP;
              binIdxReg      <= '0;
              m2AddrReg      <= HIST_BASE;
              writeEnableReg <= 1'b1;
              m1AddrReg      <= IMG_BASE;
`ifdef HIST_CDF_EN
              cdfReg         <= '0;
`endif
            end else begin
              wordIdxReg <= wordIdxReg + 16'd1;
            end
          end
        end

        DUMP: begin
          binIdxReg <= binIdxReg + 1'b1;
          m2AddrReg <= m2AddrReg + 16'd1;
`ifdef HIST_CDF_EN
          cdfReg    <= cdfNext;
`endif
          if (binIdxReg == BIN_LAST) begin
            stateReg       <= DONE;
            writeEnableReg <= 1'b0;
            doneReg        <= 1'b1;
          end
        end

        DONE: begin
          doneReg  <= 1'b0;
          stateReg <= IDLE;
        end

        default: begin
          stateReg       <= IDLE;
          writeEnableReg <= 1'b0;
          doneReg        <= 1'b0;
        end
      endcase
    end
  end

  // The bus is forced to zero outside DUMP so it reads 0 after reset.
  always_comb begin
    M2_WriteBus = '0;
    if (writeEnableReg) begin
      M2_WriteBus[COUNT_W-1:0] = binCount;
`ifdef HIST_CDF_EN
      M2_WriteBus[2*COUNT_W-1:COUNT_W] = cdfNext;
`endif
    end
  end

  assign busy            = (stateReg != IDLE);
  assign done            = doneReg;
  assign M1_ReadAddress  = m1AddrReg;
  assign M2_WriteEnable  = writeEnableReg;
  assign M2_WriteAddress = m2AddrReg;

endmodule

// File: tb/tb_hist_accumulate.sv
// -----------------------------------------------------------------------------
// tb_hist_accumulate
// Two instances: A (NUM_WORDS=4, COUNT_W=20, M1/M2 bases chosen so both
// address streams wrap past 16'hFFFF) and B (NUM_WORDS=2, COUNT_W=4, for
// saturation). A behavioural model computes the expected histogram from the
// image contents and the expected output timeline from the cycle offset
// since the start-sampling edge; one compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_hist_accumulate;

  localparam int          NW_A  = 4;
  localparam int          CW_A  = 20;
  localparam logic [15:0] IMG_A = 16'hFFFE;
  localparam logic [15:0] HB_A  = 16'hFF80;
  localparam int          NW_B  = 2;
  localparam int          CW_B  = 4;
  localparam logic [15:0] IMG_B = 16'h0040;
  localparam logic [15:0] HB_B  = 16'h0100;

  localparam logic [127:0] BYTE_K   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] GARBAGE  = {16{8'hC3}};
  localparam logic [127:0] SENTINEL = 128'hDEAD_BEEF;

  logic clock;
  logic reset_n;
  logic [1:0]        startV, busyV, doneV, weV;
  logic [1:0][15:0]  m1Addr, m2Addr;
  logic [1:0][127:0] m1Bus, m2Bus;

  int          nw      [2] = '{NW_A, NW_B};
  int          cw      [2] = '{CW_A, CW_B};
  logic [15:0] imgBase [2] = '{IMG_A, IMG_B};
  logic [15:0] hb      [2] = '{HB_A, HB_B};

  logic [127:0] imgMem [2][8];
  logic [127:0] m2Mem  [2][256];
  int           expHist[2][256];

  bit running [2];
  int t       [2];
  int startCyc[2];
  int doneCyc [2];
  int writes  [2];
  int doneCnt [2];
  int strayWr [2];

  logic         pendWe  [2];
  logic         pendDone[2];
  logic [15:0]  pendAddr[2];
  logic [127:0] pendBus [2];

  int cyc        = 0;
  int nCompared  = 0;
  int nFail      = 0;

  hist_accumulate #(
    .NUM_WORDS(NW_A), .IMG_BASE(IMG_A), .HIST_BASE(HB_A), .COUNT_W(CW_A)
  ) dutA (
    .clock(clock), .reset_n(reset_n), .start(startV[0]), .busy(busyV[0]),
    .done(doneV[0]), .M1_ReadAddress(m1Addr[0]), .M1_ReadBus(m1Bus[0]),
    .M2_WriteEnable(weV[0]), .M2_WriteAddress(m2Addr[0]), .M2_WriteBus(m2Bus[0])
  );

  hist_accumulate #(
    .NUM_WORDS(NW_B), .IMG_BASE(IMG_B), .HIST_BASE(HB_B), .COUNT_W(CW_B)
  ) dutB (
    .clock(clock), .reset_n(reset_n), .start(startV[1]), .busy(busyV[1]),
    .done(doneV[1]), .M1_ReadAddress(m1Addr[1]), .M1_ReadBus(m1Bus[1]),
    .M2_WriteEnable(weV[1]), .M2_WriteAddress(m2Addr[1]), .M2_WriteBus(m2Bus[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Combinational image SRAM; addresses outside the image return a pattern
  // that would visibly corrupt bin 0xC3 if ever counted.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      m1Bus[d] = GARBAGE;
      if (16'(m1Addr[d] - imgBase[d]) < 16'(nw[d]))
        m1Bus[d] = imgMem[d][3'(m1Addr[d] - imgBase[d])];
    end
  end

  task automatic check(input string name, input int d,
                       input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s dut%0d: got %h required %h", name, d, act, exp);
    end
  endtask

  task automatic buildModel(input int d);
    int maxc;
    int p;
    maxc = (1 << cw[d]) - 1;
    for (int b = 0; b < 256; b++) expHist[d][b] = 0;
    for (int j = 0; j < nw[d]; j++)
      for (int k = 0; k < 16; k++) begin
        p = int'(imgMem[d][j][k*8 +: 8]);
        if (expHist[d][p] < maxc) expHist[d][p]++;
      end
  endtask

  // Model + compare. Timeline offset t=0 is the READ cycle after the
  // start-sampling edge; t=1..16N counting; t=16N+1..16N+256 dump bin
  // t-16N-1; t=16N+257 the done cycle.
  initial begin : monitor
    int tt, n16, b, cdf, maxc;
    logic expWe;
    logic [127:0] expData;
    logic [15:0] off;
    for (int d = 0; d < 2; d++) begin
      running[d] = 0; t[d] = 0; writes[d] = 0; doneCnt[d] = 0;
      doneCyc[d] = 0; startCyc[d] = 0; strayWr[d] = 0;
      pendWe[d] = 0; pendDone[d] = 0; pendAddr[d] = '0; pendBus[d] = '0;
    end
    forever begin
      @(posedge clock);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (reset_n) begin
          if (pendWe[d]) begin
            off = pendAddr[d] - hb[d];
            if (off < 16'd256) m2Mem[d][off[7:0]] = pendBus[d];
            else strayWr[d]++;
            writes[d]++;
          end
          if (pendDone[d]) begin
            doneCnt[d]++;
            doneCyc[d] = cyc - startCyc[d];
          end
          if (running[d]) begin
            if (t[d] == 16*nw[d] + 257) running[d] = 0;
            else t[d]++;
          end else if (startV[d]) begin
            running[d] = 1; t[d] = 0; startCyc[d] = cyc;
            buildModel(d);
          end
        end else begin
          running[d] = 0;
        end
      end

      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        pendWe[d] = weV[d]; pendDone[d] = doneV[d];
        pendAddr[d] = m2Addr[d]; pendBus[d] = m2Bus[d];
        if (!reset_n) begin
          running[d] = 0;
          check("rst_busy", d, 128'(busyV[d]), 128'd0);
          check("rst_done", d, 128'(doneV[d]), 128'd0);
          check("rst_we", d, 128'(weV[d]), 128'd0);
          check("rst_m1addr", d, 128'(m1Addr[d]), 128'(imgBase[d]));
          check("rst_m2addr", d, 128'(m2Addr[d]), 128'd0);
          check("rst_m2bus", d, m2Bus[d], 128'd0);
        end else if (running[d]) begin
          tt = t[d];
          n16 = 16*nw[d];
          expWe = (tt >= n16 + 1) && (tt <= n16 + 256);
          check("busy", d, 128'(busyV[d]), 128'd1);
          check("done", d, 128'(doneV[d]), 128'(tt == n16 + 257));
          check("we", d, 128'(weV[d]), 128'(expWe));
          if (tt <= n16)
            check("m1addr", d, 128'(m1Addr[d]), 128'(16'(imgBase[d] + 16'(tt/16))));
          if (expWe) begin
            b = tt - n16 - 1;
            maxc = (1 << cw[d]) - 1;
            check("m2addr", d, 128'(m2Addr[d]), 128'(16'(hb[d] + 16'(b))));
            expData = 128'(expHist[d][b]);
`ifdef HIST_CDF_EN
            cdf = 0;
            for (int i = 0; i <= b; i++) cdf += expHist[d][i];
            if (cdf > maxc) cdf = maxc;
            expData = expData | (128'(cdf) << cw[d]);
`else
            cdf = 0;
`endif
            check("m2bus", d, m2Bus[d], expData);
          end
        end else begin
          check("idle_busy", d, 128'(busyV[d]), 128'd0);
          check("idle_we", d, 128'(weV[d]), 128'd0);
          check("idle_done", d, 128'(doneV[d]), 128'd0);
        end
      end
    end
  end

  task automatic pulseStart(input logic [1:0] which);
    @(negedge clock); #1 startV = which;
    @(negedge clock); #1 startV = 2'b00;
  endtask

  task automatic clearM2(input int d);
    for (int b = 0; b < 256; b++) m2Mem[d][b] = SENTINEL;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin : stimulus
    int w0, d0, w1, d1;
    bit found;
    reset_n = 1'b0;
    startV  = 2'b00;
    for (int j = 0; j < 8; j++) begin
      imgMem[0][j] = '0;
      imgMem[1][j] = {16{8'hFF}};
    end
    clearM2(0); clearM2(1);
    waitCycles(3);
    #1 reset_n = 1'b1;
    waitCycles(2);

    // Pass 1: A all-zero, B all-0xFF with 4-bit bins (saturation).
    w0 = writes[0]; d0 = doneCnt[0]; w1 = writes[1]; d1 = doneCnt[1];
    pulseStart(2'b11);
    waitCycles(340);
    check("p1_writes", 0, 128'(writes[0] - w0), 128'd256);
    check("p1_done_count", 0, 128'(doneCnt[0] - d0), 128'd1);
    check("p1_done_cycle", 0, 128'(doneCyc[0]), 128'd322);
    check("p1_bin0", 0, m2Mem[0][0], 128'd64);
    check("p1_bin1", 0, m2Mem[0][1], 128'd0);
    check("p1_bin255", 0, m2Mem[0][255][19:0], 128'd0);
    check("p1_writes", 1, 128'(writes[1] - w1), 128'd256);
    check("p1_done_count", 1, 128'(doneCnt[1] - d1), 128'd1);
    check("p1_done_cycle", 1, 128'(doneCyc[1]), 128'd290);
    check("p1_bin255_sat", 1, 128'(m2Mem[1][255][3:0]), 128'd15);
    check("p1_bin0", 1, m2Mem[1][0], 128'd0);
    $display("pass 1: A writes=%0d bin0=%0d | B writes=%0d bin255=%0d",
             writes[0] - w0, m2Mem[0][0][19:0], writes[1] - w1, m2Mem[1][255][3:0]);

    // Pass 2: byte-k image, second start mid-COUNT must be ignored.
    for (int j = 0; j < 8; j++) imgMem[0][j] = BYTE_K;
    clearM2(0);
    w0 = writes[0]; d0 = doneCnt[0];
    pulseStart(2'b01);
    waitCycles(20);
    pulseStart(2'b01);
    waitCycles(320);
    check("p2_writes", 0, 128'(writes[0] - w0), 128'd256);
    check("p2_done_count", 0, 128'(doneCnt[0] - d0), 128'd1);
    check("p2_bin15", 0, 128'(m2Mem[0][15][19:0]), 128'd4);
    check("p2_bin16", 0, 128'(m2Mem[0][16][19:0]), 128'd0);
`ifdef HIST_CDF_EN
    check("p2_cdf3", 0, 128'(m2Mem[0][3][39:20]), 128'd16);
    check("p2_cdf15", 0, 128'(m2Mem[0][15][39:20]), 128'd64);
    check("p2_cdf255", 0, 128'(m2Mem[0][255][39:20]), 128'd64);
`else
    check("p2_upper15", 0, 128'(m2Mem[0][15][127:20]), 128'd0);
`endif
    $display("pass 2: A writes=%0d done=%0d bin15=%0d", writes[0] - w0,
             doneCnt[0] - d0, m2Mem[0][15][19:0]);

    // Pass 3: immediate repeat, bins recleared, identical output.
    clearM2(0);
    w0 = writes[0]; d0 = doneCnt[0];
    pulseStart(2'b01);
    waitCycles(330);
    check("p3_writes", 0, 128'(writes[0] - w0), 128'd256);
    check("p3_done_cycle", 0, 128'(doneCyc[0]), 128'd322);
    check("p3_bin7", 0, 128'(m2Mem[0][7][19:0]), 128'd4);
    $display("pass 3: A writes=%0d bin7=%0d", writes[0] - w0, m2Mem[0][7][19:0]);

    // Passes 4/5: random image, start held across DONE -> back-to-back.
    for (int j = 0; j < 4; j++) imgMem[0][j] = {$urandom, $urandom, $urandom, $urandom};
    w0 = writes[0]; d0 = doneCnt[0];
    @(negedge clock); #1 startV = 2'b01;
    waitCycles(400);
    #1 startV = 2'b00;
    waitCycles(300);
    check("p45_writes", 0, 128'(writes[0] - w0), 128'd512);
    check("p45_done_count", 0, 128'(doneCnt[0] - d0), 128'd2);
    $display("pass 4/5: A writes=%0d done=%0d", writes[0] - w0, doneCnt[0] - d0);

    // Pass 6: reset for one cycle while bin 100 is on the bus.
    for (int j = 0; j < 4; j++) imgMem[0][j] = BYTE_K;
    clearM2(0);
    w0 = writes[0]; d0 = doneCnt[0];
    pulseStart(2'b01);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clock);
      if (weV[0] && m2Addr[0] == 16'(HB_A + 16'd100)) found = 1;
    end
    check("p6_bin100_reached", 0, 128'(found), 128'd1);
    #1 reset_n = 1'b0;
    @(negedge clock); #1 reset_n = 1'b1;
    waitCycles(300);
    check("p6_writes", 0, 128'(writes[0] - w0), 128'd100);
    check("p6_done_count", 0, 128'(doneCnt[0] - d0), 128'd0);
    check("p6_bin5", 0, 128'(m2Mem[0][5][19:0]), 128'd4);
    check("p6_bin100_dropped", 0, m2Mem[0][100], SENTINEL);
    $display("pass 6: A writes=%0d done=%0d (aborted)", writes[0] - w0, doneCnt[0] - d0);

    // Pass 7: normal run after the abort.
    clearM2(0);
    w0 = writes[0]; d0 = doneCnt[0];
    pulseStart(2'b01);
    waitCycles(330);
    check("p7_writes", 0, 128'(writes[0] - w0), 128'd256);
    check("p7_done_count", 0, 128'(doneCnt[0] - d0), 128'd1);
    check("p7_bin200", 0, 128'(m2Mem[0][200][19:0]), 128'd0);
    check("p7_bin0", 0, 128'(m2Mem[0][0][19:0]), 128'd4);
    check("stray_writes", 0, 128'(strayWr[0]), 128'd0);
    check("stray_writes", 1, 128'(strayWr[1]), 128'd0);
    $display("pass 7: A writes=%0d done=%0d", writes[0] - w0, doneCnt[0] - d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
